// File: rtl/multibyte_adder_seq.sv
// Byte-serial wide adder around an 8-bit ripple slice, one byte per cycle.
// Optional subtract mode is enabled with the MBADD_SUB_EN macro.

module adder_8bits (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

module multibyte_adder_seq #(
   parameter int NBYTES = 4,
   parameter int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin,
`ifdef MBADD_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [IW-1:0] idx;
   logic          carry;
   logic          sub_q;
   logic          sub_in;
   logic [7:0]    a_byte;
   logic [7:0]    b_byte;
   logic [7:0]    s_byte;
   logic          c_out;

`ifdef MBADD_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   // Subtraction is a + ~b + 1, so invert B per byte and force the seed carry.
   assign a_byte = a_q[8*idx +: 8];
   assign b_byte = b_q[8*idx +: 8] ^ {8{sub_q}};

   adder_8bits u_add (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry),
      .s    (s_byte),
      .cout (c_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         idx   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sub_q <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  sub_q <= sub_in;
                  carry <= sub_in | cin;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[8*idx +: 8] <= s_byte;
               carry <= c_out;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  cout  <= c_out;
                  ovf   <= (a_byte[7] == b_byte[7]) &&
                           (s_byte[7] != a_byte[7]);
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Directed-vector bench for multibyte_adder_seq (NBYTES=4).
// Build with +define+MBADD_SUB_EN to also cover subtract mode.

module tb_multibyte_adder_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
`ifdef MBADD_SUB_EN
   logic         sub_r;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int nchk;
   int npass;

   multibyte_adder_seq #(.NBYTES(NB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
`ifdef MBADD_SUB_EN
      .sub   (sub_r),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic c,
                         input logic [W-1:0] es,
                         input logic ec,
                         input logic eo);
      int n;
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      step();
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      check({tag, " busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      check({tag, " lat"}, 64'(n), 64'(NB + 1));
      check({tag, " sum"}, 64'(sum), 64'(es));
      check({tag, " cout"}, 64'(cout), 64'(ec));
      check({tag, " ovf"}, 64'(ovf), 64'(eo));
      step();
      check({tag, " done1"}, 64'(done), 64'd0);
      check({tag, " idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int ndone;
      int busy_bad;
      nchk  = 0;
      npass = 0;
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
`ifdef MBADD_SUB_EN
      sub_r = 1'b0;
`endif
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst sum", 64'(sum), 64'd0);
      check("rst cout", 64'(cout), 64'd0);
      check("rst ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      step();

      run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0,
             32'h0000_0100, 1'b0, 1'b0);
      run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
             32'h0000_0000, 1'b1, 1'b0);
      run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
      run_op("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0,
             32'h0000_0000, 1'b1, 1'b1);
      run_op("mix", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
             32'hACF1_3569, 1'b0, 1'b0);

      // start while busy must be ignored
      op_a  = 32'h1;
      op_b  = 32'h2;
      cin   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      op_a  = 32'h10;
      op_b  = 32'h10;
      start = 1'b1;
      step();
      start = 1'b0;
      ndone    = 0;
      busy_bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         if (ndone == 0 && !busy) busy_bad++;
         step();
      end
      check("t4 ndone", 64'(ndone), 64'd1);
      check("t4 busy", 64'(busy_bad), 64'd0);
      check("t4 sum", 64'(sum), 64'h3);

      // reset mid-operation (idx==2)
      op_a  = 32'hFFFF_FFFF;
      op_b  = 32'h0000_0001;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5 busy", 64'(busy), 64'd0);
      check("t5 done", 64'(done), 64'd0);
      check("t5 sum", 64'(sum), 64'd0);
      check("t5 cout", 64'(cout), 64'd0);
      check("t5 ovf", 64'(ovf), 64'd0);
      ndone = 0;
      for (int i = 0; i < NB + 4; i++) begin
         if (done) ndone++;
         step();
      end
      check("t5 nodone", 64'(ndone), 64'd0);
      run_op("t5 new", 32'h0000_0003, 32'h0000_0004, 1'b1,
             32'h0000_0008, 1'b0, 1'b0);

`ifdef MBADD_SUB_EN
      sub_r = 1'b1;
      run_op("t6a", 32'h5, 32'h7, 1'b0,
             32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("t6b", 32'h8000_0000, 32'h1, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b1);
      sub_r = 1'b0;
`endif

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
